// File: rtl/pulse_apu_bank.sv
// Bank of CHANNELS NES-style pulse voices mixed into one left-aligned DAC word.
// Latency: a register write reaches dac/active two clk edges later (state update, then output register).
// Backpressure: none; the byte-write port accepts one write per cycle unconditionally.
module pulse_apu_bank #(
   parameter int CHANNELS  = 2,
   parameter int DAC_WIDTH = 6,
   parameter int PRESCALE  = 2,
   parameter int FRAME_DIV = 14915
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wr_en,
   input  logic [4:0]           wr_addr,
   input  logic [7:0]           wr_data,
   output logic [DAC_WIDTH-1:0] dac,
   output logic [CHANNELS-1:0]  active,
   output logic                 frame_tick
);

   localparam int SW = 4 + $clog2(CHANNELS);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int FW = $clog2(FRAME_DIV);
   localparam logic [5:0] ADDR_LIM = 6'(CHANNELS * 4);

   logic [PW-1:0]          pre_cnt;
   logic [FW-1:0]          frame_cnt;
   logic                   tick;
   logic                   wr_ok;
   logic [2:0]             wr_ch;
   logic [1:0]             wr_reg;
   logic [3:0]             contrib [CHANNELS];
   logic [SW-1:0]          sum;
   logic [DAC_WIDTH-1:0]   dac_next;
   logic [CHANNELS-1:0]    act_next;

   // Duty table: bit n of the pattern is the output level during sequencer step n.
   function automatic logic duty_bit(input logic [1:0] d, input logic [2:0] s);
      logic [7:0] pat;
      pat = 8'b0000_0010;
      case (d)
         2'd0: pat = 8'b0000_0010;
         2'd1: pat = 8'b0000_0110;
         2'd2: pat = 8'b0001_1110;
         2'd3: pat = 8'b1111_1001;
         default: pat = 8'b0000_0010;
      endcase
      return pat[s];
   endfunction

   assign tick       = (pre_cnt == PW'(PRESCALE - 1));
   assign frame_tick = (frame_cnt == FW'(FRAME_DIV - 1));

   // Free-running timer prescaler; wraps after PRESCALE clks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pre_cnt <= '0;
      else if (tick) pre_cnt <= '0;
      else           pre_cnt <= pre_cnt + PW'(1);
   end

   // Free-running envelope frame divider; wraps after FRAME_DIV clks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          frame_cnt <= '0;
      else if (frame_tick) frame_cnt <= '0;
      else                 frame_cnt <= frame_cnt + FW'(1);
   end

   // Out-of-range addresses never reach any channel.
   assign wr_ok  = wr_en && ({1'b0, wr_addr} < ADDR_LIM);
   assign wr_ch  = wr_addr[4:2];
   assign wr_reg = wr_addr[1:0];

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [1:0]  duty;
      logic        loop_en;
      logic        const_vol;
      logic        enable;
      logic [3:0]  vol;
      logic [3:0]  level;
      logic [3:0]  env_div;
      logic [10:0] period;
      logic [10:0] timer;
      logic [2:0]  step;
      logic        hit;
      logic        pat_bit;

      assign hit = wr_ok && (wr_ch == 3'(g));

      // Register writes win over timer/envelope updates in the same cycle.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            duty      <= '0;
            loop_en   <= 1'b0;
            const_vol <= 1'b0;
            vol       <= '0;
            period    <= '0;
            enable    <= 1'b0;
            timer     <= '0;
            step      <= '0;
            level     <= '0;
            env_div   <= '0;
         end else if (hit) begin
            case (wr_reg)
               2'd0: begin
                  duty      <= wr_data[7:6];
                  loop_en   <= wr_data[5];
                  const_vol <= wr_data[4];
                  vol       <= wr_data[3:0];
               end
               2'd1: period[7:0]  <= wr_data;
               2'd2: period[10:8] <= wr_data[2:0];
               default: begin
                  enable  <= wr_data[0];
                  step    <= '0;
                  timer   <= period;
                  level   <= 4'd15;
                  env_div <= vol;
               end
            endcase
         end else begin
            if (tick) begin
               if (timer == '0) begin
                  timer <= period;
                  step  <= step + 3'd1;
               end else begin
                  timer <= timer - 11'd1;
               end
            end
            if (frame_tick) begin
               if (env_div == '0) begin
                  env_div <= vol;
                  if (level != '0)  level <= level - 4'd1;
                  else if (loop_en) level <= 4'd15;
               end else begin
                  env_div <= env_div - 4'd1;
               end
            end
         end
      end

      // Pattern lookup for the current sequencer step.
      always_comb pat_bit = duty_bit(duty, step);

      // Periods below 8 are ultrasonic and are muted; the timer keeps running.
      assign contrib[g] = (enable && (period[10:3] != 8'd0) && pat_bit)
                          ? (const_vol ? vol : level) : 4'd0;
   end

   // Sum all channel contributions and flag the audible ones.
   always_comb begin
      sum      = '0;
      act_next = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum         = sum + SW'(contrib[i]);
         act_next[i] = (contrib[i] != 4'd0);
      end
   end

   if (DAC_WIDTH < SW) begin : g_trunc
      assign dac_next = sum[SW-1 -: DAC_WIDTH];
   end else if (DAC_WIDTH == SW) begin : g_exact
      assign dac_next = sum;
   end else begin : g_pad
      assign dac_next = {sum, {(DAC_WIDTH - SW){1'b0}}};
   end

   // Output register for the mixed word and activity flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dac    <= '0;
         active <= '0;
      end else begin
         dac    <= dac_next;
         active <= act_next;
      end
   end

endmodule

// File: tb/tb_pulse_apu_bank.sv
// Self-checking bench for pulse_apu_bank with a behavioural reference model.
// Model advances once per clk from the spec rules; outputs are compared at negedge.
// Stimulus is directed scenarios plus $urandom register traffic.
module tb_pulse_apu_bank;

   localparam int CH = 2;
   localparam int DW = 6;
   localparam int PS = 2;
   localparam int FD = 16;
   localparam int SW = 4 + $clog2(CH);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr_en = 1'b0;
   logic [4:0]    wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic [DW-1:0] dac;
   logic [CH-1:0] active;
   logic          frame_tick;

   int n_chk = 0;
   int n_fail = 0;

   pulse_apu_bank #(.CHANNELS(CH), .DAC_WIDTH(DW), .PRESCALE(PS), .FRAME_DIV(FD)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .dac(dac), .active(active), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Duty patterns written left to right as step 0..7.
   bit [7:0] pat_txt [4] = '{8'b01000000, 8'b01100000, 8'b01111000, 8'b10011111};
   int m_duty[CH], m_loop[CH], m_cv[CH], m_vol[CH], m_per[CH], m_en[CH];
   int m_tmr[CH], m_stp[CH], m_lvl[CH], m_div[CH];
   int m_pre, m_frm, m_sum, m_amp, m_cont;
   bit m_hi, m_tick, m_ftick;
   logic [DW-1:0] m_dac;
   logic [CH-1:0] m_act;
   logic          m_ft;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pre = 0; m_frm = 0; m_dac = '0; m_act = '0; m_ft = 1'b0;
         for (int c = 0; c < CH; c++) begin
            m_duty[c] = 0; m_loop[c] = 0; m_cv[c] = 0; m_vol[c] = 0; m_per[c] = 0;
            m_en[c] = 0; m_tmr[c] = 0; m_stp[c] = 0; m_lvl[c] = 0; m_div[c] = 0;
         end
      end else begin
         // Registered outputs reflect the state held before this edge.
         m_sum = 0;
         for (int c = 0; c < CH; c++) begin
            m_amp  = (m_cv[c] != 0) ? m_vol[c] : m_lvl[c];
            m_hi   = pat_txt[m_duty[c]][7 - m_stp[c]];
            m_cont = (m_en[c] != 0 && m_per[c] >= 8 && m_hi) ? m_amp : 0;
            m_act[c] = (m_cont != 0);
            m_sum += m_cont;
         end
         if (DW >= SW) m_dac = DW'(m_sum * (1 << (DW - SW)));
         else          m_dac = DW'(m_sum / (1 << (SW - DW)));
         m_tick  = (m_pre == PS - 1);
         m_ftick = (m_frm == FD - 1);
         m_pre   = (m_pre + 1) % PS;
         m_frm   = (m_frm + 1) % FD;
         m_ft    = (m_frm == FD - 1);
         for (int c = 0; c < CH; c++) begin
            if (wr_en && wr_addr < 4 * CH && wr_addr / 4 == c) begin
               case (wr_addr % 4)
                  0: begin
                     m_duty[c] = wr_data / 64; m_loop[c] = (wr_data / 32) % 2;
                     m_cv[c] = (wr_data / 16) % 2; m_vol[c] = wr_data % 16;
                  end
                  1: m_per[c] = (m_per[c] / 256) * 256 + wr_data;
                  2: m_per[c] = (wr_data % 8) * 256 + m_per[c] % 256;
                  default: begin
                     m_en[c] = wr_data % 2; m_stp[c] = 0; m_tmr[c] = m_per[c];
                     m_lvl[c] = 15; m_div[c] = m_vol[c];
                  end
               endcase
            end else begin
               if (m_tick) begin
                  if (m_tmr[c] == 0) begin
                     m_tmr[c] = m_per[c];
                     m_stp[c] = (m_stp[c] + 1) % 8;
                  end else m_tmr[c] -= 1;
               end
               if (m_ftick) begin
                  if (m_div[c] == 0) begin
                     m_div[c] = m_vol[c];
                     if (m_lvl[c] > 0) m_lvl[c] -= 1;
                     else if (m_loop[c] != 0) m_lvl[c] = 15;
                  end else m_div[c] -= 1;
               end
            end
         end
      end
   end

   // One write per call; entered and left at a negedge.
   task automatic wr(input logic [4:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int last, cnt;
      repeat (3) @(negedge clk);
      n_chk++; if (dac !== '0) begin n_fail++; $display("FAIL reset_dac got=%0d want=0", dac); end
      n_chk++; if (active !== '0) begin n_fail++; $display("FAIL reset_active got=%b want=0", active); end
      n_chk++; if (frame_tick !== 1'b0) begin n_fail++; $display("FAIL reset_frame_tick got=%b want=0", frame_tick); end
      rst_n = 1'b1;
      last = -1; cnt = 0;
      for (int k = 1; k <= 1000; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== '0 || active !== '0) begin
            n_fail++; $display("FAIL idle_quiet k=%0d dac=%0d active=%b want 0/0", k, dac, active);
         end
         if (frame_tick === 1'b1) begin
            cnt++;
            if (last >= 0) begin
               n_chk++;
               if (k - last != FD) begin n_fail++; $display("FAIL frame_interval got=%0d want=%0d", k - last, FD); end
            end
            last = k;
         end
      end
      n_chk++; if (cnt != 62) begin n_fail++; $display("FAIL frame_count got=%0d want=62", cnt); end
   endtask

   task automatic test_single();
      int hi, lo, w;
      wr(5'd0, 8'h9F); wr(5'd1, 8'h08); wr(5'd2, 8'h00); wr(5'd3, 8'h01);
      w = 0;
      while (dac === '0 && w < 300) begin @(negedge clk); w++; end
      n_chk++; if (w >= 300) begin n_fail++; $display("FAIL single_rise timeout dac=%0d want=30", dac); end
      n_chk++; if (dac !== 6'd30 || active !== 2'b01) begin
         n_fail++; $display("FAIL single_level dac=%0d active=%b want 30/01", dac, active);
      end
      hi = 0; while (dac === 6'd30 && hi < 300) begin @(negedge clk); hi++; end
      lo = 0; while (dac === '0 && lo < 300) begin @(negedge clk); lo++; end
      n_chk++; if (hi != 72) begin n_fail++; $display("FAIL single_high_len got=%0d want=72", hi); end
      n_chk++; if (lo != 72) begin n_fail++; $display("FAIL single_low_len got=%0d want=72", lo); end
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== m_dac || active !== m_act || frame_tick !== m_ft) begin
            n_fail++; $display("FAIL single_model dac=%0d/%0d act=%b/%b ft=%b/%b", dac, m_dac, active, m_act, frame_tick, m_ft);
         end
      end
   endtask

   task automatic test_both();
      bit seen;
      wr(5'd0, 8'h9F); wr(5'd1, 8'h08); wr(5'd2, 8'h00); wr(5'd3, 8'h01);
      wr(5'd4, 8'h9F); wr(5'd5, 8'h08); wr(5'd6, 8'h00); wr(5'd7, 8'h01);
      seen = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== m_dac || active !== m_act || frame_tick !== m_ft) begin
            n_fail++; $display("FAIL both_model dac=%0d/%0d act=%b/%b ft=%b/%b", dac, m_dac, active, m_act, frame_tick, m_ft);
         end
         if (dac === 6'd60 && active === 2'b11) seen = 1;
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL both_overlap never saw dac=60 active=11 last dac=%0d", dac); end
   endtask

   task automatic test_mute();
      int w;
      wr(5'd7, 8'h00);
      wr(5'd1, 8'h07);
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== '0 || active[0] !== 1'b0 || dac !== m_dac || active !== m_act) begin
            n_fail++; $display("FAIL mute_quiet dac=%0d active=%b want 0/00", dac, active);
         end
      end
      wr(5'd1, 8'h08);
      w = 0;
      while (dac === '0 && w < 300) begin
         @(negedge clk); w++;
         n_chk++;
         if (dac !== m_dac || active !== m_act) begin
            n_fail++; $display("FAIL unmute_model dac=%0d/%0d act=%b/%b", dac, m_dac, active, m_act);
         end
      end
      n_chk++; if (dac !== 6'd30) begin n_fail++; $display("FAIL unmute_level dac=%0d want=30", dac); end
   endtask

   task automatic test_envelope();
      bit seen;
      wr(5'd0, 8'h80); wr(5'd3, 8'h01);
      for (int k = 0; k < 20 * FD; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== m_dac || active !== m_act || frame_tick !== m_ft) begin
            n_fail++; $display("FAIL env_model dac=%0d/%0d act=%b/%b", dac, m_dac, active, m_act);
         end
      end
      for (int k = 0; k < 150; k++) begin
         @(negedge clk);
         n_chk++; if (dac !== '0) begin n_fail++; $display("FAIL env_hold0 dac=%0d want=0", dac); end
      end
      wr(5'd0, 8'hA0); wr(5'd3, 8'h01);
      seen = 0;
      for (int k = 0; k < 40 * FD; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== m_dac || active !== m_act || frame_tick !== m_ft) begin
            n_fail++; $display("FAIL envloop_model dac=%0d/%0d act=%b/%b", dac, m_dac, active, m_act);
         end
         if (k >= 40 * FD - 200 && dac !== '0) seen = 1;
      end
      n_chk++; if (!seen) begin n_fail++; $display("FAIL env_loop_wrap dac stuck at %0d want nonzero", dac); end
   endtask

   task automatic test_ignored();
      for (int a = 8; a < 32; a++) begin
         wr(5'(a), 8'($urandom));
         n_chk++;
         if (dac !== m_dac || active !== m_act) begin
            n_fail++; $display("FAIL ignored_addr a=%0d dac=%0d/%0d act=%b/%b", a, dac, m_dac, active, m_act);
         end
      end
   endtask

   task automatic test_random();
      int a;
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== m_dac || active !== m_act || frame_tick !== m_ft) begin
            n_fail++; $display("FAIL random_model k=%0d dac=%0d/%0d act=%b/%b", k, dac, m_dac, active, m_act);
         end
         wr_en = ($urandom_range(0, 5) == 0);
         a = $urandom_range(0, 11);
         wr_addr = 5'(a);
         wr_data = 8'($urandom);
         if (a % 4 == 2) wr_data = wr_data & 8'h01;
      end
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic test_midreset();
      int w;
      wr(5'd0, 8'h9F); wr(5'd1, 8'h08); wr(5'd2, 8'h00); wr(5'd3, 8'h01);
      w = 0;
      while (dac === '0 && w < 300) begin @(negedge clk); w++; end
      n_chk++; if (w >= 300) begin n_fail++; $display("FAIL midreset_arm timeout dac=%0d", dac); end
      #2 rst_n = 1'b0;
      #1;
      n_chk++; if (dac !== '0 || active !== '0) begin
         n_fail++; $display("FAIL async_reset dac=%0d active=%b want 0/00", dac, active);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         n_chk++;
         if (dac !== '0 || active !== '0 || frame_tick !== m_ft) begin
            n_fail++; $display("FAIL post_reset dac=%0d active=%b ft=%b/%b", dac, active, frame_tick, m_ft);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_both();
      test_mute();
      test_envelope();
      test_ignored();
      test_random();
      test_midreset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
